flash_read_responder: RTL and testbench
=======================================

FLASH_READ_RESPONDER -- requirements
Module: flash_read_responder

Interface
REQ-001 Parameter ADDR_W, default 23, word-address width of the read port.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter DEPTH, default 4096, number of valid words in the backing store; legal addresses are 0..DEPTH-1.
REQ-004 Parameter LATENCY, default 3, busy cycles between request accept and data return; legal range 1..15.
REQ-005 Ports, one per line:
 clk  input  1  single clock, all logic on rising edge
 reset  input  1  asynchronous, active-low reset
 address  input  ADDR_W  requested word address
 read  input  1  read request from initiator
 waitrequest  output  1  high = responder busy, request not accepted
 readdata  output  DATA_W  returned word, held until next return
 readdatavalid  output  1  one-cycle pulse, readdata valid this cycle
 addr_error  output  1  one-cycle pulse with readdatavalid when address >= DEPTH
 read_count  output  16  count of completed reads

Function
REQ-006 FSM states: IDLE, BUSY, FETCH, RETURN.
REQ-007 IDLE: waitrequest=0; request accepted on a rising edge where read=1; address latched; next state BUSY.
REQ-008 BUSY: waitrequest=1; down-counter loaded with LATENCY-1 on accept, decrements each cycle; at 0 go to FETCH.
REQ-009 FETCH: waitrequest=1; word-store read issued with latched address; store read latency exactly 1 cycle; next state RETURN.
REQ-010 RETURN: waitrequest=0, readdatavalid=1 for exactly one cycle, readdata updated, read_count incremented; next state IDLE.
REQ-011 Accept-to-readdatavalid latency: LATENCY+2 cycles (accept edge to the edge where readdatavalid is registered high is LATENCY+1 further edges).
REQ-012 address, read sampled only in IDLE; changes to either during BUSY/FETCH/RETURN ignored; an accepted transaction always completes even if read drops.
REQ-013 read=1 in RETURN is not accepted; accepted in the following IDLE cycle (no back-to-back accept).
REQ-014 address >= DEPTH: store not read, readdata = 32'hDEAD_BEEF (truncated/zero-extended to DATA_W), addr_error=1 with readdatavalid; timing identical to a legal read.
REQ-015 readdata holds its last returned value in all states other than RETURN.
REQ-016 read_count wraps 16'hFFFF -> 16'h0000; errored reads are counted.
REQ-017 Latched address width ADDR_W; store indexed by low clog2(DEPTH) bits only after range check.

Reset
REQ-018 reset low asynchronously forces state IDLE, counter 0, latched address 0.
REQ-019 During and after reset: waitrequest=0, readdatavalid=0, addr_error=0, readdata=0, read_count=0.
REQ-020 Reset asserted mid-transaction abandons it; no readdatavalid pulse follows reset release for that request.
REQ-021 First accept possible on the first rising edge after reset deasserts.

Structure
REQ-022 Shared package flash_pkg holds: state enum typedef, ERR_WORD constant (32'hDEAD_BEEF), default ADDR_W/DATA_W.
REQ-023 One sub-module, flash_word_rom: synchronous single-port read store, DEPTH x DATA_W, registered output, initialised from a memory file.
REQ-024 FSM, counter, range check and output registers live in flash_read_responder.

Verification
REQ-025 Store word 5 = 32'h1234_5678, LATENCY=3; read=1 address=5 for one cycle in IDLE -> waitrequest high 4 cycles, readdatavalid pulse with readdata 32'h1234_5678, read_count=1.
REQ-026 address=DEPTH (4096) read -> readdata 32'hDEAD_BEEF, addr_error and readdatavalid pulse together, same latency as REQ-025.
REQ-027 Hold read=1 continuously, address 0 then 1 -> two accepts separated by one IDLE cycle, data words 0 then 1, no accept in RETURN.
REQ-028 Change address from 5 to 9 during BUSY -> returned word is word 5.
REQ-029 Assert reset 2 cycles after accept -> all outputs 0 immediately; after release, no readdatavalid for 20 cycles without new read.
REQ-030 Preload read_count to 16'hFFFF via 65535 reads (or force) -> next completed read gives read_count=0.

Source files
------------

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared types, constants and store image for the flash read responder
package flash_pkg;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 32;

  // Returned in place of store data when the requested address is past the end of the store
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_FETCH  = 2'd2,
    ST_RETURN = 2'd3
  } state_e;

  // Contents of the word store: word 5 carries a fixed signature, every other word
  // carries its own index in the low half and the inverted index in the high half.
  function automatic logic [31:0] image_word(input logic [15:0] idx);
    if (idx == 16'd5) begin
      return 32'h1234_5678;
    end
    return {~idx, idx};
  endfunction

endpackage

// File: rtl/flash_word_rom.sv
// rtl/flash_word_rom.sv - synchronous single-port read-only word store with registered output
module flash_word_rom
  import flash_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [IDX_W-1:0]  addr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Look up the addressed word only when a read is issued; otherwise hold the last word
  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = DATA_W'(image_word(16'(addr)));
    end
  end

  // Output register of the store; contents are constant so no reset is needed
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/flash_read_responder.sv
// rtl/flash_read_responder.sv - fixed-latency read responder in front of a word store
module flash_read_responder
  import flash_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              addr_error,
  output logic [15:0]       read_count
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT    = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              waitrequest_q, waitrequest_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              readdatavalid_q, readdatavalid_d;
  logic              addr_error_q, addr_error_d;
  logic [15:0]       read_count_q, read_count_d;

  logic              out_of_range;
  logic              rom_en;
  logic [DATA_W-1:0] rom_rdata;

  // Range check on the latched address; the store only ever sees in-range indices
  assign out_of_range = ({1'b0, addr_q} >= LIMIT);

  // The store is addressed on the edge that enters FETCH, so its registered word
  // is ready during FETCH and is captured into readdata on the edge into RETURN.
  assign rom_en = (state_q == ST_BUSY) && (cnt_q == 4'd0) && !out_of_range;

  flash_word_rom #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_rom (
    .clk   (clk),
    .en    (rom_en),
    .addr  (addr_q[IDX_W-1:0]),
    .rdata (rom_rdata)
  );

  // Next-state and next-output logic; outputs are registered so they reflect the state entered
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    waitrequest_d   = 1'b0;
    readdata_d      = readdata_q;
    readdatavalid_d = 1'b0;
    addr_error_d    = 1'b0;
    read_count_d    = read_count_q;

    case (state_q)
      ST_IDLE: begin
        if (read) begin
          state_d       = ST_BUSY;
          addr_d        = address;
          cnt_d         = CNT_LOAD;
          waitrequest_d = 1'b1;
        end
      end
      ST_BUSY: begin
        waitrequest_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_FETCH: begin
        state_d         = ST_RETURN;
        readdatavalid_d = 1'b1;
        addr_error_d    = out_of_range;
        readdata_d      = out_of_range ? DATA_W'(ERR_WORD) : rom_rdata;
        read_count_d    = read_count_q + 16'd1;
      end
      ST_RETURN: begin
        // A request seen here is left for the following IDLE cycle
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 4'd0;
      addr_q          <= '0;
      waitrequest_q   <= 1'b0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      addr_error_q    <= 1'b0;
      read_count_q    <= 16'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      waitrequest_q   <= waitrequest_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      addr_error_q    <= addr_error_d;
      read_count_q    <= read_count_d;
    end
  end

  assign waitrequest   = waitrequest_q;
  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign addr_error    = addr_error_q;
  assign read_count    = read_count_q;

endmodule

// File: tb/tb_flash_read_responder.sv
// tb/tb_flash_read_responder.sv - scoreboard bench for flash_read_responder
module tb_flash_read_responder;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4096;
  localparam int LATENCY = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              read = 1'b0;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              addr_error;
  logic [15:0]       read_count;

  flash_read_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .addr_error    (addr_error),
    .read_count    (read_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          wr_cnt  = 0;
  logic [15:0] exp_count = 16'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected store contents, written out independently of the design
  function automatic logic [31:0] model_word(input int unsigned a);
    logic [15:0] lo;
    if (a >= DEPTH) return 32'hDEAD_BEEF;
    if (a == 5) return 32'h1234_5678;
    lo = a[15:0];
    return {~lo, lo};
  endfunction

  function automatic exp_t make_exp(input int unsigned a, input int accept_cyc);
    exp_t e;
    exp_count = exp_count + 16'd1;
    e.data = model_word(a);
    e.err  = (a >= DEPTH);
    e.cnt  = exp_count;
    e.cyc  = accept_cyc + LATENCY + 1;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor: compare each returned word against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (waitrequest) wr_cnt++;
    if (addr_error && !readdatavalid) check("err_without_rdv", addr_error, 1'b0);
    if (readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("rdv_without_request", readdatavalid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("readdata", readdata, e.data);
        check("addr_error", addr_error, e.err);
        check("read_count", read_count, e.cnt);
        check("rdv_cycle", cyc, e.cyc);
      end
    end
  end

  // Called just after a rising edge with the DUT idle: one-cycle read pulse
  task automatic issue(input int unsigned a);
    address = a[ADDR_W-1:0];
    read = 1'b1;
    exp_q.push_back(make_exp(a, cyc + 1));
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_waitrequest", waitrequest, 1'b0);
    check("rst_readdatavalid", readdatavalid, 1'b0);
    check("rst_addr_error", addr_error, 1'b0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_read_count", read_count, 16'h0);

    // Basic read of word 5, accepted on the first edge after reset release
    reset = 1'b1;
    wr_cnt = 0;
    issue(5);
    wait_done();
    check("busy_cycles_legal", wr_cnt, 4);
    check("readdata_hold", readdata, 32'h1234_5678);

    // Out-of-range read at exactly DEPTH, same latency
    wr_cnt = 0;
    issue(DEPTH);
    wait_done();
    check("busy_cycles_err", wr_cnt, 4);
    check("readdata_hold_err", readdata, 32'hDEAD_BEEF);

    // Last legal word and the top of the address space
    issue(DEPTH - 1);
    wait_done();
    issue(23'h7F_FFFF);
    wait_done();

    // read held high: accepts for words 0 then 1, nothing taken in RETURN
    address = '0;
    read = 1'b1;
    exp_q.push_back(make_exp(0, cyc + 1));
    @(posedge clk); #1;
    address = 23'd1;
    exp_q.push_back(make_exp(1, cyc + LATENCY + 3));
    repeat (LATENCY + 3) @(posedge clk);
    #1;
    read = 1'b0;
    wait_done();

    // Address and read changes during the transaction are ignored
    address = 23'd5;
    read = 1'b1;
    exp_q.push_back(make_exp(5, cyc + 1));
    @(posedge clk); #1;
    read = 1'b0;
    address = 23'd9;
    @(posedge clk); #1;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    wait_done();

    // Reset two cycles after accept abandons the transaction
    issue(7);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_waitrequest", waitrequest, 1'b0);
    check("mid_rst_readdatavalid", readdatavalid, 1'b0);
    check("mid_rst_addr_error", addr_error, 1'b0);
    check("mid_rst_readdata", readdata, 32'h0);
    check("mid_rst_read_count", read_count, 16'h0);
    exp_q.delete();
    exp_count = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle_count", read_count, 16'h0);

    // A few pseudo-random addresses, some beyond the store
    for (int i = 0; i < 6; i++) begin
      issue($urandom_range(0, DEPTH + 900));
      wait_done();
    end

    // read_count wrap from 16'hFFFF
    force dut.read_count_q = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    release dut.read_count_q;
    exp_count = 16'hFFFF;
    @(posedge clk); #1;
    check("count_preload", read_count, 16'hFFFF);
    issue(DEPTH + 3);
    wait_done();
    issue(2);
    wait_done();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
